// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage and the rest of the core / instruction memory.
// The slave modport is the fetch stage's view; the master modport is the surrounding core.
interface if_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  env_exception;
  logic                  bp_exception;
  logic                  mret_req;
  logic                  dbg_resume;
  logic [DATA_WIDTH-1:0] dbg_resume_pc;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] ifid_pc;
  logic [DATA_WIDTH-1:0] ifid_pc4;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic                  ifid_valid;
  logic [DATA_WIDTH-1:0] epc;
  logic                  fetch_misalign;
  logic                  halted;
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_flush_cnt;

  modport slave (
    input  stall, branch_taken, branch_target, env_exception, bp_exception, mret_req,
           dbg_resume, dbg_resume_pc, imem_rdata,
    output imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, epc, fetch_misalign,
           halted, perf_stall_cnt, perf_flush_cnt
  );

  modport master (
    output stall, branch_taken, branch_target, env_exception, bp_exception, mret_req,
           dbg_resume, dbg_resume_pc, imem_rdata,
    input  imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, epc, fetch_misalign,
           halted, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/if_stage.sv
// rv32i fetch stage with IF/ID register, trap/mret redirect and debug HALT on ebreak.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC   = 32'h0000_0100,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.slave   bus
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  localparam logic [DATA_WIDTH-1:0] PcStep    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] AlignMask = ~DATA_WIDTH'(3);

  state_e                r_state;
  logic                  r_halted;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ifid_pc;
  logic [DATA_WIDTH-1:0] r_ifid_pc4;
  logic [DATA_WIDTH-1:0] r_ifid_instr;
  logic                  r_ifid_valid;
  logic [DATA_WIDTH-1:0] r_epc;
  logic                  r_fetch_misalign;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_branch_pc;
  logic [DATA_WIDTH-1:0] w_resume_pc;
  logic                  w_branch_misalign;
  logic                  w_run;
  logic                  w_run_flush;
  logic                  w_run_stall;

  assign w_pc_plus4        = r_pc + PcStep;
  assign w_branch_pc       = bus.branch_target & AlignMask;
  assign w_resume_pc       = bus.dbg_resume_pc & AlignMask;
  assign w_branch_misalign = (bus.branch_target[1:0] != 2'b00);

  // Qualified events in RUN, already resolved against higher-priority requests.
  assign w_run       = (r_state == StRun);
  assign w_run_flush = w_run && !bus.bp_exception &&
                       (bus.env_exception || bus.mret_req || bus.branch_taken);
  assign w_run_stall = w_run && !bus.bp_exception && !bus.env_exception &&
                       !bus.mret_req && !bus.branch_taken && bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StRun;
      r_halted         <= 1'b0;
      r_pc             <= RESET_PC;
      r_ifid_pc        <= '0;
      r_ifid_pc4       <= PcStep;
      r_ifid_instr     <= NOP_INSTR;
      r_ifid_valid     <= 1'b0;
      r_epc            <= '0;
      r_fetch_misalign <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (bus.bp_exception) begin
            r_state      <= StHalt;
            r_halted     <= 1'b1;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end else if (bus.env_exception) begin
            r_pc         <= TRAP_VEC;
            r_epc        <= r_ifid_pc;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end else if (bus.mret_req) begin
            r_pc         <= r_epc;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end else if (bus.branch_taken) begin
            // Redirect beats a concurrent stall: the stalled instruction is squashed anyway.
            r_pc             <= w_branch_pc;
            r_fetch_misalign <= r_fetch_misalign | w_branch_misalign;
            r_ifid_instr     <= NOP_INSTR;
            r_ifid_valid     <= 1'b0;
          end else if (!bus.stall) begin
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_instr <= bus.imem_rdata;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_plus4;
          end
        end
        StHalt: begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          if (bus.dbg_resume) begin
            r_state  <= StRun;
            r_halted <= 1'b0;
            r_pc     <= w_resume_pc;
          end
        end
        default: begin
          r_state  <= StRun;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_run_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_run_flush) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`else
  logic w_perf_unused;
  assign w_perf_unused      = w_run_stall ^ w_run_flush;
  assign bus.perf_stall_cnt = 32'h0;
  assign bus.perf_flush_cnt = 32'h0;
`endif

  assign bus.imem_addr      = r_pc;
  assign bus.ifid_pc        = r_ifid_pc;
  assign bus.ifid_pc4       = r_ifid_pc4;
  assign bus.ifid_instr     = r_ifid_instr;
  assign bus.ifid_valid     = r_ifid_valid;
  assign bus.epc            = r_epc;
  assign bus.fetch_misalign = r_fetch_misalign;
  assign bus.halted         = r_halted;

endmodule
